// File: rtl/execute_mdu_multicycle.sv
// ----------------------------------------------------------------------------
// execute_mdu_multicycle
//
// Multi-cycle M-extension unit that sits beside the single-cycle ALU in the
// execute stage. It accepts one MUL/DIV/REM op per valid/ready handshake and
// returns an XLEN-bit result through a valid/ready output handshake.
//   - Multiply: full 2*XLEN product with a counted latency of MUL_STAGES cycles.
//   - Divide/remainder: restoring divider, one quotient bit per cycle, working
//     on operand magnitudes with a sign fix-up on the way into DONE.
//   - Divide by zero and signed overflow finish one cycle after accept.
//
// Optional feature (macro MDU_DIVREM_CACHE_EN):
//   When defined, a completed DIV/DIVU keeps its operands, signedness,
//   quotient and remainder. A later DIV-class op with the same operands and
//   signedness is answered from that store in one cycle.
//
// Parameters
//   XLEN        operand/result width (>= 8, even)
//   MUL_STAGES  multiply latency in cycles, 1..4
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     synchronous active-low reset
//   flush      in   1     kill in-flight op (branch/jump redirect)
//   in_valid   in   1     op1/op2/func3 valid
//   in_ready   out  1     unit can accept an op (FSM in IDLE)
//   op1        in   XLEN  rs1 value / dividend / multiplicand
//   op2        in   XLEN  rs2 value / divisor / multiplier
//   func3      in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                         100 DIV,101 DIVU,110 REM,111 REMU
//   out_valid  out  1     result valid, held until accepted
//   out_ready  in   1     consumer takes result
//   result     out  XLEN  op result
//   busy       out  1     op accepted and not yet retired
// ----------------------------------------------------------------------------
module execute_mdu_multicycle #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      func3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   MUL_LAST = CW'((MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] a_q, a_nx, b_q, b_nx;
    logic [1:0]      f_q, f_nx;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic [XLEN-1:0] quo_q, quo_nx, rem_q, rem_nx, dsr_q, dsr_nx;
    logic            neg_quo_q, neg_quo_nx, neg_rem_q, neg_rem_nx;
    logic [XLEN-1:0] res_q, res_nx;

    // Multiplier operands come straight from the inputs in IDLE so that a
    // single-stage multiply can finish on the accept edge; otherwise they
    // come from the latched copies.
    logic [XLEN-1:0]   mul_a, mul_b, mul_res;
    logic [1:0]        mul_f;
    logic              mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;

    always_comb begin
        mul_a        = (state == IDLE) ? op1 : a_q;
        mul_b        = (state == IDLE) ? op2 : b_q;
        mul_f        = (state == IDLE) ? func3[1:0] : f_q;
        mul_a_signed = (mul_f != 2'b11);
        mul_b_signed = ~mul_f[1];
        mul_a_ext    = {{XLEN{mul_a_signed & mul_a[XLEN-1]}}, mul_a};
        mul_b_ext    = {{XLEN{mul_b_signed & mul_b[XLEN-1]}}, mul_b};
        mul_prod     = mul_a_ext * mul_b_ext;
        mul_res      = (mul_f == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Divide set-up from the incoming operands: magnitudes, result signs and
    // the two cases that bypass the iteration.
    logic            in_signed, in_a_neg, in_b_neg, div_by_zero, div_ovf;
    logic [XLEN-1:0] in_a_mag, in_b_mag;

    always_comb begin
        in_signed   = ~func3[0];
        in_a_neg    = in_signed & op1[XLEN-1];
        in_b_neg    = in_signed & op2[XLEN-1];
        in_a_mag    = in_a_neg ? -op1 : op1;
        in_b_mag    = in_b_neg ? -op2 : op2;
        div_by_zero = (op2 == '0);
        div_ovf     = in_signed && (op1 == SMIN) && (op2 == '1);
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The partial remainder
    // stays below the divisor, so the low XLEN bits of the difference are exact.
    logic [XLEN:0]   shifted;
    logic            borrow;
    logic [XLEN-1:0] diff_lo, step_quo, step_rem, fin_quo, fin_rem;

    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        borrow   = (shifted < {1'b0, dsr_q});
        diff_lo  = shifted[XLEN-1:0] - dsr_q;
        step_rem = borrow ? shifted[XLEN-1:0] : diff_lo;
        step_quo = {quo_q[XLEN-2:0], ~borrow};
        fin_quo  = neg_quo_q ? -step_quo : step_quo;
        fin_rem  = neg_rem_q ? -step_rem : step_rem;
    end

    logic            c_hit;
    logic [XLEN-1:0] c_res;

`ifdef MDU_DIVREM_CACHE_EN
    logic            c_valid_q, c_valid_nx, c_signed_q, c_signed_nx;
    logic [XLEN-1:0] c_a_q, c_a_nx, c_b_q, c_b_nx;
    logic [XLEN-1:0] c_quo_q, c_quo_nx, c_rem_q, c_rem_nx;

    assign c_hit = c_valid_q && (c_a_q == op1) && (c_b_q == op2) && (c_signed_q == in_signed);
    assign c_res = func3[1] ? c_rem_q : c_quo_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid_q  <= 1'b0;
            c_signed_q <= 1'b0;
            c_a_q      <= '0;
            c_b_q      <= '0;
            c_quo_q    <= '0;
            c_rem_q    <= '0;
        end else begin
            c_valid_q  <= c_valid_nx;
            c_signed_q <= c_signed_nx;
            c_a_q      <= c_a_nx;
            c_b_q      <= c_b_nx;
            c_quo_q    <= c_quo_nx;
            c_rem_q    <= c_rem_nx;
        end
    end
`else
    assign c_hit = 1'b0;
    assign c_res = '0;
`endif

    // Next-state and datapath updates. Flush overrides everything and only
    // returns the FSM to IDLE (and drops the cached division).
    always_comb begin
        state_nx   = state;
        a_nx       = a_q;
        b_nx       = b_q;
        f_nx       = f_q;
        cnt_nx     = cnt_q;
        quo_nx     = quo_q;
        rem_nx     = rem_q;
        dsr_nx     = dsr_q;
        neg_quo_nx = neg_quo_q;
        neg_rem_nx = neg_rem_q;
        res_nx     = res_q;
`ifdef MDU_DIVREM_CACHE_EN
        c_valid_nx  = c_valid_q;
        c_signed_nx = c_signed_q;
        c_a_nx      = c_a_q;
        c_b_nx      = c_b_q;
        c_quo_nx    = c_quo_q;
        c_rem_nx    = c_rem_q;
`endif
        if (flush) begin
            state_nx = IDLE;
`ifdef MDU_DIVREM_CACHE_EN
            c_valid_nx = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_nx   = op1;
                        b_nx   = op2;
                        f_nx   = func3[1:0];
                        cnt_nx = '0;
                        if (!func3[2]) begin
                            if (MUL_STAGES == 1) begin
                                res_nx   = mul_res;
                                state_nx = DONE;
                            end else begin
                                state_nx = MUL;
                            end
                        end else begin
`ifdef MDU_DIVREM_CACHE_EN
                            if (!c_hit) c_valid_nx = 1'b0;
`endif
                            if (div_by_zero) begin
                                res_nx   = func3[1] ? op1 : '1;
                                state_nx = DONE;
                            end else if (div_ovf) begin
                                res_nx   = func3[1] ? '0 : op1;
                                state_nx = DONE;
                            end else if (c_hit) begin
                                res_nx   = c_res;
                                state_nx = DONE;
                            end else begin
                                quo_nx     = in_a_mag;
                                rem_nx     = '0;
                                dsr_nx     = in_b_mag;
                                neg_quo_nx = in_a_neg ^ in_b_neg;
                                neg_rem_nx = in_a_neg;
                                state_nx   = DIV;
                            end
                        end
                    end
                end
                MUL: begin
                    cnt_nx = cnt_q + CW'(1);
                    if (cnt_q == MUL_LAST) begin
                        res_nx   = mul_res;
                        state_nx = DONE;
                    end
                end
                DIV: begin
                    quo_nx = step_quo;
                    rem_nx = step_rem;
                    cnt_nx = cnt_q + CW'(1);
                    if (cnt_q == DIV_LAST) begin
                        res_nx   = f_q[1] ? fin_rem : fin_quo;
                        state_nx = DONE;
`ifdef MDU_DIVREM_CACHE_EN
                        if (!f_q[1]) begin
                            c_valid_nx  = 1'b1;
                            c_signed_nx = ~f_q[0];
                            c_a_nx      = a_q;
                            c_b_nx      = b_q;
                            c_quo_nx    = fin_quo;
                            c_rem_nx    = fin_rem;
                        end
`endif
                    end
                end
                DONE: begin
                    if (out_ready) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state     <= state_nx;
            a_q       <= a_nx;
            b_q       <= b_nx;
            f_q       <= f_nx;
            cnt_q     <= cnt_nx;
            quo_q     <= quo_nx;
            rem_q     <= rem_nx;
            dsr_q     <= dsr_nx;
            neg_quo_q <= neg_quo_nx;
            neg_rem_q <= neg_rem_nx;
            res_q     <= res_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = res_q;

endmodule

// File: tb/tb_execute_mdu_multicycle.sv
// ----------------------------------------------------------------------------
// tb_execute_mdu_multicycle
//
// Self-checking bench for execute_mdu_multicycle (XLEN=32, MUL_STAGES=2).
// Directed table of ops with known results and latencies, hand-written
// sequences for flush, reset and output back-pressure, then random ops
// checked against an arithmetic reference model. Honours MDU_DIVREM_CACHE_EN.
// ----------------------------------------------------------------------------
module tb_execute_mdu_multicycle;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
`ifdef MDU_DIVREM_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif
    localparam int          DIV_LAT = XLEN + 1;
    localparam int          HIT_LAT = CACHE_EN ? 1 : DIV_LAT;
    localparam logic [31:0] SMIN    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] op1, op2, result;
    logic [2:0]  func3;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state for the optional division store
    bit          m_valid;
    logic [31:0] m_a, m_b;
    bit          m_signed;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    always #5 clk = ~clk;

    execute_mdu_multicycle #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .func3     (func3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Architectural result computed with plain 64-bit arithmetic
    function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == SMIN) && (b == 32'hFFFF_FFFF);
        p   = 64'(0);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    // Expected latency (accept edge counted as 1) and division-store tracking
    task automatic modelIssue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                              output int lat);
        bit sgn, special, hit;
        if (!f[2]) begin
            lat = MUL_STAGES;
            return;
        end
        sgn     = !f[0];
        special = (b == 0) || (sgn && a == SMIN && b == 32'hFFFF_FFFF);
        hit     = CACHE_EN && m_valid && (a == m_a) && (b == m_b) && (sgn == m_signed);
        if (!hit) m_valid = 1'b0;
        if (special || hit) begin
            lat = 1;
        end else begin
            lat = DIV_LAT;
            if (CACHE_EN && !f[1]) begin
                m_valid  = 1'b1;
                m_a      = a;
                m_b      = b;
                m_signed = sgn;
            end
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
    endtask

    // Issue one op, measure edges until out_valid, capture result, retire it
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         output logic [31:0] res, output int lat, output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        op1      = a;
        op2      = b;
        func3    = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        ok  = out_valid;
        res = result;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [31:0] res;
        int          lat, exp_lat;
        bit          ok;
        runOp(a, b, f, res, lat, ok);
        modelIssue(a, b, f, exp_lat);
        checkOutput("rand_done", 32'(ok), 32'd1);
        checkOutput("rand_result", res, refResult(a, b, f));
        checkOutput("rand_latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] res, a, b, prev_a, prev_b;
        logic [2:0]  f;
        int          lat, guard, mode;
        bit          ok, seen;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; func3 = '0;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_signed = 1'b0;

        vecs[0]  = '{32'd7,         32'hFFFF_FFFD, 3'd0, 32'hFFFF_FFEB, MUL_STAGES};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFE, MUL_STAGES};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd2,         3'd2, 32'hFFFF_FFFF, MUL_STAGES};
        vecs[3]  = '{SMIN,          SMIN,          3'd1, 32'h4000_0000, MUL_STAGES};
        vecs[4]  = '{32'h0001_0000, 32'h0001_0000, 3'd0, 32'h0000_0000, MUL_STAGES};
        vecs[5]  = '{32'hFFFF_FFEC, 32'd3,         3'd4, 32'hFFFF_FFFA, DIV_LAT};
        vecs[6]  = '{32'hFFFF_FFEC, 32'd3,         3'd6, 32'hFFFF_FFFE, HIT_LAT};
        vecs[7]  = '{32'd5,         32'd0,         3'd5, 32'hFFFF_FFFF, 1};
        vecs[8]  = '{32'd5,         32'd0,         3'd6, 32'd5,         1};
        vecs[9]  = '{SMIN,          32'hFFFF_FFFF, 3'd4, SMIN,          1};
        vecs[10] = '{SMIN,          32'hFFFF_FFFF, 3'd6, 32'd0,         1};
        vecs[11] = '{32'd100,       32'd7,         3'd5, 32'd14,        DIV_LAT};
        vecs[12] = '{32'd100,       32'd7,         3'd7, 32'd2,         HIT_LAT};
        vecs[13] = '{32'd100,       32'd7,         3'd6, 32'd2,         DIV_LAT};
        vecs[14] = '{32'd100,       32'd7,         3'd7, 32'd2,         DIV_LAT};
        vecs[15] = '{32'd7,         32'hFFFF_FFFE, 3'd4, 32'hFFFF_FFFD, DIV_LAT};
        vecs[16] = '{32'd7,         32'hFFFF_FFFE, 3'd6, 32'd1,         HIT_LAT};
        vecs[17] = '{SMIN,          32'hFFFF_FFFF, 3'd5, 32'd0,         DIV_LAT};
        vecs[18] = '{32'hFFFF_FFF9, 32'd2,         3'd4, 32'hFFFF_FFFD, DIV_LAT};
        vecs[19] = '{32'hFFFF_FFF9, 32'd2,         3'd6, 32'hFFFF_FFFF, HIT_LAT};

        resetDut();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_result", result, 32'd0);

        for (int i = 0; i < 20; i++) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].f, res, lat, ok);
            checkOutput($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].res);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Result held under back-pressure, and no accept on the retire edge
        @(negedge clk);
        op1 = 32'd3; op2 = 32'd5; func3 = 3'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        checkOutput("hold_reached", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_result", result, 32'd15);
        end
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op1 = 32'd9; op2 = 32'd9; func3 = 3'd0;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        checkOutput("retire_out_valid", 32'(out_valid), 32'd0);
        checkOutput("retire_no_accept", 32'(busy), 32'd0);
        checkOutput("retire_in_ready", 32'(in_ready), 32'd1);

        // Flush a divide ten cycles into its iteration
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; func3 = 3'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("div_busy", 32'(busy), 32'd1);
        checkOutput("div_in_ready", 32'(in_ready), 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        m_valid = 1'b0;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | out_valid;
        end
        checkOutput("flush_no_output", 32'(seen), 32'd0);

        // Flush together with in_valid in IDLE drops the op
        @(negedge clk);
        op1 = 32'd50; op2 = 32'd5; func3 = 3'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        checkOutput("idle_flush_busy", 32'(busy), 32'd0);
        checkOutput("idle_flush_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 seen = seen | out_valid;
        end
        checkOutput("idle_flush_no_output", 32'(seen), 32'd0);

        // A flush in between must drop any stored division
        applyStimulus(32'd100, 32'd7, 3'd5);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        m_valid = 1'b0;
        applyStimulus(32'd100, 32'd7, 3'd7);

        // Reset in the middle of a divide abandons it
        @(negedge clk);
        op1 = 32'hFFFF_FFEC; op2 = 32'd3; func3 = 3'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_result", result, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        seen    = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | out_valid;
        end
        checkOutput("midreset_no_output", 32'(seen), 32'd0);

        // Random ops against the reference model
        resetDut();
        prev_a = 32'd1000;
        prev_b = 32'd13;
        for (int i = 0; i < 150; i++) begin
            mode = int'($urandom_range(0, 9));
            f    = 3'($urandom_range(0, 7));
            case (mode)
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = SMIN; b = 32'hFFFF_FFFF; end
                2, 3:    begin a = prev_a; b = prev_b; end
                4:       begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                5:       begin a = $urandom; b = $urandom_range(1, 255); end
                6:       begin a = $urandom; b = 32'hFFFF_FFFF - $urandom_range(0, 9); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            applyStimulus(a, b, f);
            prev_a = a;
            prev_b = b;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
